pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter and fetch-control stage directly upstream of the instruction memory. It holds the PC and drives the memory's IAddr and InsMemRW inputs. It computes the next PC from sequential, branch, jump and jump-register sources, and runs a small run/halt state machine. It also supplies PC+4 to the link path and keeps a retired-fetch counter for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
COUNT_W, 16, width of the fetch counter

Ports:
CLK  input  1  system clock, rising-edge active
Reset  input  1  synchronous, active-high reset
PCWre  input  1  PC write enable from control; 0 = stall (hold PC)
PCSrc  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 jump-register
Imm32  input  32  sign-extended branch offset, in words
JAddr  input  26  jump target field, instr[25:0]
RegAddr  input  32  rs value for jump-register
Halt  input  1  halt instruction decoded this cycle
IAddr  output  32  current PC, to instruction memory address
InsMemRW  output  1  instruction-memory read enable; 1 = fetch active
PC4  output  32  IAddr+4, combinational, for link writeback
Halted  output  1  1 while FSM is in HALT
MisalignErr  output  1  sticky: jump-register target was not word aligned
FetchCount  output  COUNT_W  number of PC updates since reset, saturating

Behaviour:
- Clock and reset: single clock domain (CLK). Reset is synchronous and active-high; all state updates on the rising edge of CLK.
- Reset values: IAddr=RESET_PC, InsMemRW=0, Halted=0, MisalignErr=0, FetchCount=0, state=IDLE. Reset has priority over every other input.
- FSM states:
  - IDLE: InsMemRW=0; PCWre, PCSrc and Halt are ignored. Unconditionally moves to RUN on the next edge.
  - RUN: InsMemRW=1; the PC update rules below apply.
  - HALT: InsMemRW=0, Halted=1, PC frozen. Leaves HALT only via Reset.
- Next-PC computation (all arithmetic mod 2^32, wrap silently):
  - seq = IAddr+4
  - branch = IAddr+4+(Imm32<<2)
  - jump = {PC4[31:28], JAddr, 2'b00}
  - jr = RegAddr
  - IAddr[1:0] is always 00 except at a misconfigured RESET_PC, which is not checked.
- RUN priority, evaluated on each edge:
  1. Halt=1: go to HALT; PC held; no count.
  2. PCWre=1, PCSrc=11, RegAddr[1:0]!=00: PC held; MisalignErr<=1; go to HALT.
  3. PCWre=1: IAddr<=next PC; FetchCount increments.
  4. PCWre=0: hold; no count.
- Update latency: the new IAddr is visible one cycle after the edge that sampled PCWre=1.
- FetchCount: saturates at all ones and does not wrap.
- PC4: purely combinational from IAddr, valid in every state.
- Outputs are registered, except PC4.
- Reset mid-operation, including in HALT: the next edge returns to IDLE with reset values. MisalignErr is cleared only by Reset.
- Undefined/X on PCSrc is not handled; control guarantees a valid encoding whenever PCWre=1.

Test Plan:
- Reset then sequence: Reset=1 for 2 cycles, then PCWre=1, PCSrc=00 -> cycle 1 after reset InsMemRW=0, IAddr=0; then InsMemRW=1 and IAddr steps 0,4,8,12; FetchCount=3 after three updates; PC4 = IAddr+4 throughout.
- Branch and wrap: IAddr=0x10, PCSrc=01, Imm32=0xFFFF_FFFE (-2) -> IAddr=0x0C. With IAddr=0xFFFF_FFFC, PCSrc=00 -> IAddr=0x0000_0000.
- Jump and jump-register: IAddr=0x4000_0010, PCSrc=10, JAddr=0x0000040 -> IAddr=0x4000_0100. PCSrc=11, RegAddr=0x0000_0200 -> IAddr=0x200.
- Stall and halt priority: PCWre=0 for 3 cycles -> IAddr and FetchCount unchanged. Halt=1 together with PCWre=1, PCSrc=00 -> IAddr unchanged, Halted=1, InsMemRW=0 next cycle, and both stay so for 10 cycles.
- Misaligned jr: PCSrc=11, RegAddr=0x0000_0102, PCWre=1 -> IAddr held, MisalignErr=1, Halted=1. Reset asserted in HALT -> next edge IAddr=RESET_PC, MisalignErr=0, Halted=0, InsMemRW=0, then RUN resumes.
- Counter saturation (COUNT_W=4): 20 sequential updates -> FetchCount stops at 15 while IAddr keeps advancing to 80.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle between control/decode and the PC/fetch unit.
// The master is the control side; the slave is the fetch unit.
interface pc_fetch_if #(
    parameter int COUNT_W = 16
);
    logic               PCWre;
    logic [1:0]         PCSrc;
    logic [31:0]        Imm32;
    logic [25:0]        JAddr;
    logic [31:0]        RegAddr;
    logic               Halt;
    logic [31:0]        IAddr;
    logic               InsMemRW;
    logic [31:0]        PC4;
    logic               Halted;
    logic               MisalignErr;
    logic [COUNT_W-1:0] FetchCount;

    modport master (
        output PCWre, PCSrc, Imm32, JAddr, RegAddr, Halt,
        input  IAddr, InsMemRW, PC4, Halted, MisalignErr, FetchCount
    );

    modport slave (
        input  PCWre, PCSrc, Imm32, JAddr, RegAddr, Halt,
        output IAddr, InsMemRW, PC4, Halted, MisalignErr, FetchCount
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control: next-PC select, run/halt FSM,
// sticky jump-register misalignment flag and saturating fetch counter.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 16
) (
    input logic        CLK,
    input logic        Reset,
    pc_fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic signed [31:0] imm_s;
    logic [31:0]        pc_seq;
    logic [31:0]        pc_branch;
    logic [31:0]        pc_jump;
    logic [31:0]        pc_next;
    logic               jr_misaligned;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (&c) ? c : c + COUNT_ONE;
    endfunction

    assign bus.PC4 = bus.IAddr + 32'd4;

    // Imm32 is a signed word offset; wrap-around is silent by design.
    assign imm_s         = bus.Imm32;
    assign pc_seq        = bus.PC4;
    assign pc_branch     = pc_seq + (imm_s <<< 2);
    assign pc_jump       = {bus.PC4[31:28], bus.JAddr, 2'b00};
    assign jr_misaligned = (bus.PCSrc == 2'b11) && (bus.RegAddr[1:0] != 2'b00);

    always_comb begin
        pc_next = pc_seq;
        case (bus.PCSrc)
            2'b00:   pc_next = pc_seq;
            2'b01:   pc_next = pc_branch;
            2'b10:   pc_next = pc_jump;
            default: pc_next = bus.RegAddr;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state           <= IDLE;
            bus.IAddr       <= RESET_PC;
            bus.InsMemRW    <= 1'b0;
            bus.Halted      <= 1'b0;
            bus.MisalignErr <= 1'b0;
            bus.FetchCount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= RUN;
                    bus.InsMemRW <= 1'b1;
                end
                RUN: begin
                    if (bus.Halt) begin
                        state        <= HALT;
                        bus.InsMemRW <= 1'b0;
                        bus.Halted   <= 1'b1;
                    end else if (bus.PCWre && jr_misaligned) begin
                        state           <= HALT;
                        bus.InsMemRW    <= 1'b0;
                        bus.Halted      <= 1'b1;
                        bus.MisalignErr <= 1'b1;
                    end else if (bus.PCWre) begin
                        bus.IAddr      <= pc_next;
                        bus.FetchCount <= sat_inc(bus.FetchCount);
                    end
                end
                HALT: begin
                    state        <= HALT;
                    bus.InsMemRW <= 1'b0;
                    bus.Halted   <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    bus.InsMemRW <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, branch/jump/jr, stall,
// halt, misaligned jr, reset recovery and counter saturation.
module tb_pc_fetch_unit;
    logic CLK;
    logic Reset;
    logic rst4;
    int   vectors;
    int   miscompares;

    pc_fetch_if #(.COUNT_W(16)) bus  ();
    pc_fetch_if #(.COUNT_W(4))  bus4 ();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(16)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(4)) dut4 (
        .CLK   (CLK),
        .Reset (rst4),
        .bus   (bus4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic rw,
                               input logic hl, input logic me, input logic [31:0] cnt);
        check({tag, ".IAddr"},       bus.IAddr, pc);
        check({tag, ".PC4"},         bus.PC4, pc + 32'd4);
        check({tag, ".InsMemRW"},    {31'd0, bus.InsMemRW}, {31'd0, rw});
        check({tag, ".Halted"},      {31'd0, bus.Halted}, {31'd0, hl});
        check({tag, ".MisalignErr"}, {31'd0, bus.MisalignErr}, {31'd0, me});
        check({tag, ".FetchCount"},  {16'd0, bus.FetchCount}, cnt);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        rst4        = 1'b1;
        bus.PCWre   = 1'b0;
        bus.PCSrc   = 2'b00;
        bus.Imm32   = 32'd0;
        bus.JAddr   = 26'd0;
        bus.RegAddr = 32'd0;
        bus.Halt    = 1'b0;
        bus4.PCWre   = 1'b1;
        bus4.PCSrc   = 2'b00;
        bus4.Imm32   = 32'd0;
        bus4.JAddr   = 26'd0;
        bus4.RegAddr = 32'd0;
        bus4.Halt    = 1'b0;

        // Reset held for two edges
        step();
        step();
        check_state("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Sequential fetch; first edge only leaves IDLE
        Reset     = 1'b0;
        bus.PCWre = 1'b1;
        bus.PCSrc = 2'b00;
        step();
        check_state("idle2run", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        check("seq1", bus.IAddr, 32'h4);
        step();
        check("seq2", bus.IAddr, 32'h8);
        step();
        check_state("seq3", 32'hC, 1'b1, 1'b0, 1'b0, 32'd3);
        step();
        check("seq4", bus.IAddr, 32'h10);

        // Backward branch by -2 words from 0x10
        bus.PCSrc = 2'b01;
        bus.Imm32 = 32'hFFFF_FFFE;
        step();
        check_state("branch", 32'h0000_000C, 1'b1, 1'b0, 1'b0, 32'd5);

        // jr to 0x4000_0010, then jump keeping PC4[31:28]
        bus.PCSrc   = 2'b11;
        bus.RegAddr = 32'h4000_0010;
        step();
        check("jr_hi", bus.IAddr, 32'h4000_0010);
        bus.PCSrc = 2'b10;
        bus.JAddr = 26'h0000040;
        step();
        check_state("jump", 32'h4000_0100, 1'b1, 1'b0, 1'b0, 32'd7);
        bus.PCSrc   = 2'b11;
        bus.RegAddr = 32'h0000_0200;
        step();
        check("jr", bus.IAddr, 32'h0000_0200);

        // Wrap at top of address space
        bus.RegAddr = 32'hFFFF_FFFC;
        step();
        check("jr_top", bus.IAddr, 32'hFFFF_FFFC);
        check("pc4_wrap", bus.PC4, 32'h0000_0000);
        bus.PCSrc = 2'b00;
        step();
        check_state("seq_wrap", 32'h0, 1'b1, 1'b0, 1'b0, 32'd10);

        // Stall for three cycles
        bus.PCWre = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.IAddr", bus.IAddr, 32'h0);
            check("stall.FetchCount", {16'd0, bus.FetchCount}, 32'd10);
        end

        // Halt wins over a pending write
        bus.PCWre = 1'b1;
        bus.Halt  = 1'b1;
        step();
        check_state("halt", 32'h0, 1'b0, 1'b1, 1'b0, 32'd10);
        bus.Halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_hold.IAddr", bus.IAddr, 32'h0);
            check("halt_hold.Halted", {31'd0, bus.Halted}, 32'd1);
            check("halt_hold.InsMemRW", {31'd0, bus.InsMemRW}, 32'd0);
        end

        // Reset out of HALT, resume running
        Reset = 1'b1;
        step();
        check_state("halt_reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        Reset = 1'b0;
        step();
        check("resume.InsMemRW", {31'd0, bus.InsMemRW}, 32'd1);
        step();
        check("resume.IAddr", bus.IAddr, 32'h4);

        // Misaligned jump-register
        bus.PCSrc   = 2'b11;
        bus.RegAddr = 32'h0000_0102;
        step();
        check_state("misalign", 32'h4, 1'b0, 1'b1, 1'b1, 32'd1);
        bus.PCSrc = 2'b00;
        step();
        check_state("misalign_hold", 32'h4, 1'b0, 1'b1, 1'b1, 32'd1);
        Reset = 1'b1;
        step();
        check_state("misalign_reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        Reset = 1'b0;
        step();
        check("rerun.InsMemRW", {31'd0, bus.InsMemRW}, 32'd1);
        step();
        check_state("rerun", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);

        // 4-bit counter saturation: one IDLE edge then 20 updates
        rst4 = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            step();
            if (i == 16) begin
                check("sat15.FetchCount", {28'd0, bus4.FetchCount}, 32'd15);
                check("sat15.IAddr", bus4.IAddr, 32'd60);
            end
        end
        check("sat.FetchCount", {28'd0, bus4.FetchCount}, 32'd15);
        check("sat.IAddr", bus4.IAddr, 32'd80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
